// File: rtl/aes_stream_ctrl.sv
// Stream front-end for an AES_top core: buffers plaintext blocks, runs one core
// operation at a time in ECB or CTR mode, and guards each operation with a timeout.
module aes_stream_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_start,
    input  logic [127:0] AES_key_in,
    input  logic [127:0] AES_iv_in,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         core_en,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_data_out,
    input  logic         core_data_out_valid,
    output logic         busy,
    output logic         timeout_err,
    output logic [1:0]   o_dbg_state
);
    // Valid/ready: a beat transfers on a rising edge where valid and ready are both high;
    // m_valid then holds with m_data stable until it is accepted.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [127:0]  r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [127:0]  r_key;
    logic [127:0]  r_ctr;
    logic [127:0]  r_pt;
    logic [TW-1:0] r_tcnt;
    logic          w_push;
    logic          w_pop;
    logic          w_done;
    logic          w_tmo;
    logic          w_out_free;
    logic          w_flush;
    logic          w_start_ok;
    logic [127:0]  w_head;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if ((r_count != '0) && w_out_free) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_done)     w_state_nxt = ST_IDLE;
                else if (w_tmo) w_state_nxt = ST_ERR;
            end
            ST_ERR:    if (AES_start) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Full blocks pushes even when a pop happens the same cycle.
    always_comb begin
        s_ready    = (r_count != CW'(FIFO_DEPTH)) && (r_state != ST_ERR);
        w_push     = s_valid && s_ready;
        w_pop      = (r_state == ST_LAUNCH);
        w_done     = (r_state == ST_WAIT) && core_data_out_valid;
        w_tmo      = (r_state == ST_WAIT) && !core_data_out_valid && (r_tcnt == TW'(TIMEOUT - 1));
        w_out_free = !m_valid || m_ready;
        w_flush    = (r_state == ST_ERR);
        w_start_ok = AES_start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
        w_head     = r_fifo[r_rd_ptr];
    end

    assign core_key    = r_key;
    assign o_dbg_state = r_state;

    always_ff @(posedge AES_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_key        <= '0;
            r_ctr        <= '0;
            r_pt         <= '0;
            r_tcnt       <= '0;
            core_en      <= 1'b0;
            core_data_in <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
        end else begin
            if (w_start_ok) begin
                r_key <= AES_key_in;
                r_ctr <= AES_iv_in;
            end else if (w_done && (MODE == 1)) begin
                r_ctr <= r_ctr + 128'd1;
            end
            if (w_pop) begin
                r_pt         <= w_head;
                core_data_in <= (MODE == 1) ? r_ctr : w_head;
                core_en      <= 1'b1;
                busy         <= 1'b1;
                r_tcnt       <= '0;
            end
            if (r_state == ST_WAIT) begin
                if (w_done || w_tmo) begin
                    core_en <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
            if (w_tmo) timeout_err <= 1'b1;
            else if (w_flush && AES_start) timeout_err <= 1'b0;
            // CTR results are keystream XOR the plaintext captured at launch.
            if (w_done) begin
                m_valid <= 1'b1;
                m_data  <= (MODE == 1) ? (core_data_out ^ r_pt) : core_data_out;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: input block FIFO depth in 128-bit entries; power of two, 2..16.
REQ-002 Parameter MODE, default 0: 0 = ECB, 1 = CTR.
REQ-003 Parameter TIMEOUT, default 64: max cycles from core launch to core_data_out_valid; range 8..1023.
REQ-004 AES_clk  in  1  single clock; all state changes on rising edge.
REQ-005 AES_rst_n  in  1  reset; asynchronous and active-low.
REQ-006 AES_start  in  1  one-cycle pulse: latch AES_key_in/AES_iv_in, clear error, load counter.
REQ-007 AES_key_in  in  128  cipher key, sampled only on AES_start.
REQ-008 AES_iv_in  in  128  CTR initial counter, sampled only on AES_start; unused when MODE=0.
REQ-009 s_valid / s_ready / s_data  in / out / in  1/1/128  plaintext stream; transfer when both valid and ready high.
REQ-010 m_valid / m_ready / m_data  out / in / out  1/1/128  result stream; same handshake rule.
REQ-011 core_en / core_data_in / core_key  out / out / out  1/128/128  drive to AES_top AES_en, AES_data_in, AES_key_in.
REQ-012 core_data_out / core_data_out_valid  in / in  128/1  from AES_top AES_data_out, AES_data_out_valid.
REQ-013 busy  out  1  high while a core operation is in flight.
REQ-014 timeout_err  out  1  sticky error flag.

Function
REQ-015 FSM states IDLE, LAUNCH, WAIT, ERR; all outputs registered except s_ready.
REQ-016 s_ready = (fifo_count != FIFO_DEPTH) and state != ERR; no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-017 Simultaneous push and pop: count unchanged, both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-018 IDLE -> LAUNCH when FIFO non-empty and output register empty (m_valid=0, or m_valid and m_ready same cycle); otherwise stay.
REQ-019 LAUNCH: pop FIFO head into plaintext holding register; core_data_in = head (ECB) or counter (CTR); core_en goes high next edge; -> WAIT.
REQ-020 WAIT: core_en and core_data_in held stable; core_key = latched key throughout.
REQ-021 WAIT -> IDLE on core_data_out_valid=1: core_en low next edge; m_data loaded; m_valid set; busy low.
REQ-022 ECB: m_data = core_data_out; CTR: m_data = core_data_out XOR held plaintext.
REQ-023 CTR counter += 1 modulo 2^128 after each completed block; all-ones wraps to zero, no flag.
REQ-024 core_en low for at least one cycle between consecutive operations.
REQ-025 Timeout counter clears at launch, increments each WAIT cycle; at TIMEOUT without valid -> ERR.
REQ-026 ERR: core_en=0, timeout_err=1, s_ready=0, FIFO contents discarded, m_valid unaffected until accepted.
REQ-027 ERR -> IDLE only on AES_start; AES_start clears timeout_err and FIFO, reloads key/counter.
REQ-028 AES_start in LAUNCH or WAIT ignored; in IDLE applies next edge, FIFO preserved.
REQ-029 core_data_out_valid outside WAIT ignored.
REQ-030 m_valid, once high, stays high with m_data stable until m_ready sampled high.
REQ-031 Minimum latency s_data accepted -> m_valid: 3 cycles + core latency.

Reset
REQ-032 AES_rst_n low asynchronously forces: state IDLE, FIFO empty, s_ready=1, m_valid=0, m_data=0, core_en=0, core_data_in=0, core_key=0, key/counter=0, busy=0, timeout_err=0.
REQ-033 Reset mid-WAIT drops the in-flight block; no m_valid after release.

Verification (bench core model: valid pulse 10 cycles after core_en rises)
REQ-034 MODE=0, start with key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, push 00000052_00000000_00000000_00000000 -> core_data_in equals it, core_key equals key, m_data equals model output, core_en high exactly 11 cycles.
REQ-035 Push 3 blocks back-to-back, m_ready=1 -> 3 results in order, core_en low >=1 cycle between ops.
REQ-036 FIFO_DEPTH=4, m_ready=0, push 6 blocks -> s_ready low after 5 accepted (4 FIFO + 1 in flight), no loss after m_ready=1.
REQ-037 MODE=1, IV ffffffff_ffffffff_ffffffff_ffffffff, 2 blocks -> core_data_in all-ones then 0; m_data = model XOR plaintext.
REQ-038 Model never asserts valid, TIMEOUT=64 -> timeout_err high at 64 cycles after launch, core_en low, s_ready 0; AES_start -> IDLE, flag clear.
REQ-039 Assert AES_rst_n=0 during WAIT -> all outputs at REQ-032 values immediately, no m_valid after release.
